// File: rtl/rng_stream_rx.sv
// AXI-Stream consumer for the 32-bit TRNG word stream: frame-length checking, byte/sum counters, FWFT FIFO.
// Optional feature macro: RNG_RX_SUM_EN enables the RX_SUM wrapping-sum accumulator.
module rng_stream_rx #(
  parameter int FIFO_AW = 4
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [31:0]        S_AXIS_TDATA,
  input  logic               S_AXIS_TLAST,
  input  logic               S_AXIS_TVALID,
  output logic               S_AXIS_TREADY,
  input  logic               RX_GO,
  input  logic               RX_STOP,
  input  logic [31:0]        RX_EXPECT_BYTES,
  output logic               RX_BUSY,
  output logic               RX_DONE,
  output logic [1:0]         RX_ERR,
  output logic [31:0]        RX_RCVD_BYTES,
  output logic [31:0]        RX_SUM,
  input  logic               RD_EN,
  output logic [31:0]        RD_DATA,
  output logic               RD_EMPTY,
  output logic [FIFO_AW:0]   RD_COUNT
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE = 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t              state_q, state_d;
  logic [31:0]         expect_q, expect_d;
  logic [31:0]         rcvd_q, rcvd_d;
  logic [1:0]          err_q, err_d;
  logic                done_q, done_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [31:0]         mem_q [DEPTH];

  logic                full, empty, accept, pop, frame_end;
  logic [1:0]          end_err;
  logic [31:0]         rcvd_inc;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full          = count_q[FIFO_AW];
  assign empty         = (count_q == '0);
  assign S_AXIS_TREADY = (state_q == RECV) && !full;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop           = RD_EN && !empty;
  assign rcvd_inc      = rcvd_q + 32'd4;

  assign RX_BUSY       = (state_q == RECV);
  assign RX_DONE       = done_q;
  assign RX_ERR        = err_q;
  assign RX_RCVD_BYTES = rcvd_q;
  assign RD_EMPTY      = empty;
  assign RD_COUNT      = count_q;
  assign RD_DATA       = empty ? 32'd0 : mem_q[rd_ptr_q];

  always_comb begin
    frame_end = 1'b0;
    end_err   = 2'd0;
    if (accept) begin
      if (expect_q == '0) begin
        frame_end = S_AXIS_TLAST;
      end else if (rcvd_inc == expect_q) begin
        frame_end = 1'b1;
        end_err   = S_AXIS_TLAST ? 2'd0 : 2'd2;
      end else if (S_AXIS_TLAST) begin
        frame_end = 1'b1;
        end_err   = 2'd1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (RX_GO) state_d = RECV;
      RECV:    if (RX_STOP || frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RX_STOP outranks frame-end, but the beat handshaken alongside it still counts
  always_comb begin
    expect_d = expect_q;
    rcvd_d   = rcvd_q;
    err_d    = err_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (RX_GO) begin
        expect_d = {RX_EXPECT_BYTES[31:2], 2'b00};
        rcvd_d   = '0;
        err_d    = 2'd0;
      end
    end else begin
      if (accept) rcvd_d = rcvd_inc;
      if (RX_STOP) begin
        err_d = 2'd3;
      end else if (frame_end) begin
        err_d  = end_err;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      expect_q <= '0;
      rcvd_q   <= '0;
      err_q    <= 2'd0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      expect_q <= expect_d;
      rcvd_q   <= rcvd_d;
      err_q    <= err_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage is not reset; RD_DATA is masked to zero while empty
  always_ff @(posedge ACLK) begin
    if (accept) mem_q[wr_ptr_q] <= S_AXIS_TDATA;
  end

`ifdef RNG_RX_SUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && RX_GO) sum_d = '0;
    else if (accept)              sum_d = sum_q + S_AXIS_TDATA;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign RX_SUM = sum_q;
`else
  assign RX_SUM = 32'd0;
`endif

endmodule

// File: tb/tb_rng_stream_rx.sv
// Directed self-checking bench for rng_stream_rx (FIFO_AW=4); honours RNG_RX_SUM_EN for RX_SUM expectations.
module tb_rng_stream_rx;

  localparam int FIFO_AW = 4;
`ifdef RNG_RX_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic              aclk, areset;
  logic [31:0]       tdata;
  logic              tlast, tvalid, tready;
  logic              rx_go, rx_stop;
  logic [31:0]       rx_expect;
  logic              rx_busy, rx_done;
  logic [1:0]        rx_err;
  logic [31:0]       rx_rcvd, rx_sum;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              rd_empty;
  logic [FIFO_AW:0]  rd_count;

  int compared   = 0;
  int mismatched = 0;

  rng_stream_rx #(.FIFO_AW(FIFO_AW)) dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXIS_TDATA(tdata), .S_AXIS_TLAST(tlast), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .RX_GO(rx_go), .RX_STOP(rx_stop), .RX_EXPECT_BYTES(rx_expect),
    .RX_BUSY(rx_busy), .RX_DONE(rx_done), .RX_ERR(rx_err),
    .RX_RCVD_BYTES(rx_rcvd), .RX_SUM(rx_sum),
    .RD_EN(rd_en), .RD_DATA(rd_data), .RD_EMPTY(rd_empty), .RD_COUNT(rd_count)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] expect_bytes);
    rx_expect = expect_bytes;
    rx_go     = 1'b1;
    step();
    rx_go     = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n      = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    while (!tready && n < 100) begin
      step();
      n++;
    end
    if (!tready) check_output("tready_timeout", {31'd0, tready}, 32'd1);
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check_output(tag, rd_data, exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_output({pfx, "_tready"}, {31'd0, tready},   32'd0);
    check_output({pfx, "_busy"},   {31'd0, rx_busy},  32'd0);
    check_output({pfx, "_done"},   {31'd0, rx_done},  32'd0);
    check_output({pfx, "_err"},    {30'd0, rx_err},   32'd0);
    check_output({pfx, "_rcvd"},   rx_rcvd,           32'd0);
    check_output({pfx, "_sum"},    rx_sum,            32'd0);
    check_output({pfx, "_empty"},  {31'd0, rd_empty}, 32'd1);
    check_output({pfx, "_count"},  {27'd0, rd_count}, 32'd0);
    check_output({pfx, "_rddata"}, rd_data,           32'd0);
  endtask

  initial begin
    areset = 1'b1; tdata = '0; tlast = 1'b0; tvalid = 1'b0;
    rx_go = 1'b0; rx_stop = 1'b0; rx_expect = '0; rd_en = 1'b0;
    #2;
    check_reset_vals("reset");
    step();
    areset = 1'b0;
    step();

    $display("[TB] good 16-byte frame");
    start_frame(32'd16);
    check_output("t1_busy",   {31'd0, rx_busy}, 32'd1);
    check_output("t1_tready", {31'd0, tready},  32'd1);
    send_beat(32'd1, 1'b0);
    check_output("t1_first_head", rd_data, 32'd1);
    check_output("t1_rcvd_4", rx_rcvd, 32'd4);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    check_output("t1_done_early", {31'd0, rx_done}, 32'd0);
    send_beat(32'd4, 1'b1);
    check_output("t1_done",   {31'd0, rx_done}, 32'd1);
    check_output("t1_err",    {30'd0, rx_err},  32'd0);
    check_output("t1_rcvd",   rx_rcvd,          32'd16);
    check_output("t1_sum",    rx_sum,           SUM_ON ? 32'd10 : 32'd0);
    check_output("t1_busy_lo",{31'd0, rx_busy}, 32'd0);
    check_output("t1_tready_lo", {31'd0, tready}, 32'd0);
    check_output("t1_count",  {27'd0, rd_count}, 32'd4);
    step();
    check_output("t1_done_once", {31'd0, rx_done}, 32'd0);
    for (int i = 1; i <= 4; i++) pop_check("t1_read", 32'(i));
    check_output("t1_empty", {31'd0, rd_empty}, 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_output("t1_pop_empty_count", {27'd0, rd_count}, 32'd0);

    $display("[TB] early TLAST");
    start_frame(32'd16);
    send_beat(32'h0000_000A, 1'b0);
    send_beat(32'h0000_000B, 1'b1);
    check_output("t2_done", {31'd0, rx_done}, 32'd1);
    check_output("t2_err",  {30'd0, rx_err},  32'd1);
    check_output("t2_rcvd", rx_rcvd,          32'd8);
    tvalid = 1'b1;
    tdata  = 32'h0000_000C;
    check_output("t2_third_tready", {31'd0, tready}, 32'd0);
    step();
    tvalid = 1'b0;
    check_output("t2_count", {27'd0, rd_count}, 32'd2);
    pop_check("t2_read_a", 32'h0000_000A);
    pop_check("t2_read_b", 32'h0000_000B);

    $display("[TB] missing TLAST, expect low bits ignored");
    start_frame(32'd11);
    send_beat(32'd5, 1'b0);
    check_output("t3_busy_mid", {31'd0, rx_busy}, 32'd1);
    send_beat(32'd6, 1'b0);
    check_output("t3_done", {31'd0, rx_done}, 32'd1);
    check_output("t3_err",  {30'd0, rx_err},  32'd2);
    check_output("t3_rcvd", rx_rcvd,          32'd8);
    pop_check("t3_read_5", 32'd5);
    pop_check("t3_read_6", 32'd6);

    $display("[TB] FIFO backpressure over 20-beat frame");
    start_frame(32'd80);
    for (int i = 0; i < 16; i++) send_beat(32'(100 + i), 1'b0);
    check_output("t4_full_tready", {31'd0, tready},   32'd0);
    check_output("t4_full_count",  {27'd0, rd_count}, 32'd16);
    tvalid = 1'b1;
    tdata  = 32'd116;
    step();
    step();
    check_output("t4_hold_count", {27'd0, rd_count}, 32'd16);
    check_output("t4_hold_rcvd",  rx_rcvd,           32'd64);
    pop_check("t4_head_100", 32'd100);
    check_output("t4_reopen_tready", {31'd0, tready}, 32'd1);
    send_beat(32'd116, 1'b0);
    check_output("t4_refull_tready", {31'd0, tready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      pop_check("t4_head", 32'(101 + k));
      send_beat(32'(117 + k), (k == 2));
    end
    check_output("t4_done", {31'd0, rx_done}, 32'd1);
    check_output("t4_err",  {30'd0, rx_err},  32'd0);
    check_output("t4_rcvd", rx_rcvd,          32'd80);
    for (int i = 104; i <= 119; i++) pop_check("t4_drain", 32'(i));
    check_output("t4_empty", {31'd0, rd_empty}, 32'd1);

    $display("[TB] unbounded frame with sum wrap");
    start_frame(32'd0);
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'h0000_0002, 1'b1);
    check_output("t5_done", {31'd0, rx_done}, 32'd1);
    check_output("t5_err",  {30'd0, rx_err},  32'd0);
    check_output("t5_sum",  rx_sum,           SUM_ON ? 32'h0000_0001 : 32'd0);
    pop_check("t5_read_ff", 32'hFFFF_FFFF);
    pop_check("t5_read_2",  32'h0000_0002);

    $display("[TB] abort, GO/STOP priority, async reset");
    start_frame(32'd16);
    send_beat(32'd7, 1'b0);
    send_beat(32'd8, 1'b0);
    send_beat(32'd9, 1'b0);
    rx_stop = 1'b1;
    step();
    rx_stop = 1'b0;
    check_output("t6_busy", {31'd0, rx_busy}, 32'd0);
    check_output("t6_err",  {30'd0, rx_err},  32'd3);
    check_output("t6_done", {31'd0, rx_done}, 32'd0);
    check_output("t6_rcvd", rx_rcvd,          32'd12);
    step();
    check_output("t6_done_after", {31'd0, rx_done}, 32'd0);
    rx_stop = 1'b1;
    step();
    rx_stop = 1'b0;
    check_output("t6_idle_stop_err", {30'd0, rx_err}, 32'd3);
    pop_check("t6_read_7", 32'd7);
    pop_check("t6_read_8", 32'd8);
    pop_check("t6_read_9", 32'd9);
    rx_expect = 32'd16;
    rx_go     = 1'b1;
    rx_stop   = 1'b1;
    step();
    rx_go     = 1'b0;
    rx_stop   = 1'b0;
    check_output("t6_go_wins_busy", {31'd0, rx_busy}, 32'd1);
    check_output("t6_go_wins_err",  {30'd0, rx_err},  32'd0);
    send_beat(32'h0000_0077, 1'b0);
    check_output("t6_mid_count", {27'd0, rd_count}, 32'd1);
    #2;
    areset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    step();
    areset = 1'b0;
    step();
    check_output("post_reset_busy", {31'd0, rx_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rng_stream_rx.md
# rng_stream_rx

AXI-Stream receiver for the TRNG random-word stream: the consumer end of the 32-bit RNG stream interface. Accepts beats under TVALID/TREADY, checks frame length against TLAST, accumulates byte count and a 32-bit wrapping sum, and buffers words in a first-word-fall-through FIFO. Sits between the RNG stream output and a local consumer (self-test logic, host-readable port, or loopback bench).

## Interface
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW words.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous reset, active-high.
- S_AXIS_TDATA  in  32  stream data beat.
- S_AXIS_TLAST  in  1  final beat of frame.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  beat accepted when TVALID&TREADY.
- RX_GO  in  1  one-cycle start pulse.
- RX_STOP  in  1  one-cycle abort pulse.
- RX_EXPECT_BYTES  in  32  expected frame length in bytes; 0 = unbounded, end on TLAST.
- RX_BUSY  out  1  high in RECV.
- RX_DONE  out  1  one-cycle pulse on frame end (good or error).
- RX_ERR  out  2  0 ok, 1 early TLAST, 2 missing TLAST, 3 aborted.
- RX_RCVD_BYTES  out  32  bytes accepted since last RX_GO.
- RX_SUM  out  32  wrapping sum of accepted words since last RX_GO.
- RD_EN  in  1  pop FIFO head.
- RD_DATA  out  32  FIFO head word (valid when !RD_EMPTY).
- RD_EMPTY  out  1  FIFO empty.
- RD_COUNT  out  FIFO_AW+1  words held.

## Operation
- States: IDLE, RECV. Reset -> IDLE.
- IDLE: RX_GO -> RECV; clears RX_RCVD_BYTES, RX_SUM, RX_ERR; latches RX_EXPECT_BYTES (bits [1:0] ignored). FIFO not flushed.
- RECV: S_AXIS_TREADY = !full (full = RD_COUNT==2**FIFO_AW; pop in same cycle does not reopen TREADY). Each accepted beat: push TDATA, RCVD += 4, SUM += TDATA (mod 2^32).
- Frame end (bounded, E = latched expect): beat with RCVD+4==E and TLAST -> ERR 0; TLAST with RCVD+4<E -> ERR 1; RCVD+4==E without TLAST -> ERR 2. Unbounded: TLAST -> ERR 0. Each case: RX_DONE pulse, -> IDLE; ending beat is still pushed and counted.
- RX_STOP in RECV: -> IDLE, ERR 3, no RX_DONE; a beat handshaken that same cycle is still accepted. RX_STOP has priority over frame-end detection; RX_STOP in IDLE ignored.
- RX_GO in RECV ignored. RX_GO and RX_STOP same cycle in IDLE: GO wins.
- FIFO: circular, wraps at depth; RD_EN when empty ignored; push and pop same cycle keep RD_COUNT.

## Timing
- Reset values: S_AXIS_TREADY 0, RX_BUSY 0, RX_DONE 0, RX_ERR 0, RX_RCVD_BYTES 0, RX_SUM 0, RD_EMPTY 1, RD_COUNT 0, RD_DATA 0.
- TREADY combinational from registered state and count only (no path from TVALID).
- RX_GO at cycle n -> RX_BUSY/TREADY high at n+1.
- Beat accepted at n -> RD_EMPTY low, RD_DATA valid, counters updated at n+1.
- Ending beat at n -> RX_DONE high for cycle n+1 only, RX_BUSY low, TREADY low from n+1.
- RD_EN at n with !RD_EMPTY -> next word (or RD_EMPTY) at n+1.
- Counters wrap silently at 2^32.

## Configuration
- RNG_RX_SUM_EN defined: RX_SUM accumulates as above.
- Not defined: sum adder removed, RX_SUM constant 0; all other behaviour identical.

## Test plan
- EXPECT=16, GO, four beats 1,2,3,4 with TLAST on 4th -> RX_DONE once, ERR 0, RCVD 16, SUM 10, FIFO reads 1,2,3,4.
- EXPECT=16, TLAST on 2nd beat -> DONE, ERR 1, RCVD 8; third beat offered gets TREADY 0.
- EXPECT=8, two beats no TLAST -> DONE, ERR 2, RCVD 8.
- FIFO_AW=4, RD_EN held 0, 20-beat frame -> TREADY drops after 16 beats; pop one -> TREADY high next cycle; full frame completes with order preserved.
- EXPECT=0, beats 0xFFFFFFFF, 0x00000002 with TLAST -> ERR 0, SUM 0x00000001 (wrap; 0 without RNG_RX_SUM_EN).
- RX_STOP after 3 beats of 16 -> BUSY low, ERR 3, no DONE; ARESET mid-frame -> all outputs at reset values asynchronously.
